// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine blocks: dispenser state encoding,
// coin values and the millisecond-to-clock-cycle conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLA_ON   = 2'd1,
        ST_CHANGE_ON = 2'd2,
        ST_GAP       = 2'd3
    } vend_state_t;

    // Coin values in half-coin units.
    localparam int unsigned COIN_HALF = 1;
    localparam int unsigned COIN_ONE  = 2;
    localparam int unsigned COLA_PRICE = 5;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/vend_ms_timer.sv
// Loadable down-counter; stops at zero and flags it. Load has priority over counting.
module vend_ms_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_seq.sv
// Cola/change solenoid sequencer with request queueing and timed hold/gap phases.
// Define VEND_DISPENSE_RR_EN for round-robin arbitration instead of strict cola priority.
module vend_dispense_seq
    import vend_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned PULSE_MS = 200,
    parameter int unsigned GAP_MS   = 100,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pi_cola,
    input  logic             pi_change,
    output logic             po_cola_drv,
    output logic             po_change_drv,
    output logic             po_busy,
    output logic             po_overflow,
    output logic [CNT_W-1:0] po_cola_pend,
    output logic [CNT_W-1:0] po_change_pend
);

    localparam int unsigned HOLD_CYC = ms_to_cyc(CLK_HZ, PULSE_MS);
    localparam int unsigned GAP_CYC  = ms_to_cyc(CLK_HZ, GAP_MS);
    localparam int unsigned TMAX     = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int          TW       = $clog2(TMAX + 1);
    localparam logic [CNT_W-1:0] PMAX = '1;

    vend_state_t      state_q, state_d;
    logic [CNT_W-1:0] cola_pend_q, cola_pend_d;
    logic [CNT_W-1:0] change_pend_q, change_pend_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, cola_drv_q, change_drv_q;

    logic             tmr_load, tmr_zero;
    logic [TW-1:0]    tmr_val, tmr_cnt;
    logic             launch, pick_cola, pick_change, prefer_cola;
    logic             start_cola, start_change, cola_acc, change_acc;

    vend_ms_timer #(.W(TW)) u_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

`ifdef VEND_DISPENSE_RR_EN
    // Set when cola was the last type started; reset value favours cola on the first tie.
    logic last_cola_q, last_cola_d;

    always_comb begin
        last_cola_d = last_cola_q;
        if (start_cola)
            last_cola_d = 1'b1;
        else if (start_change)
            last_cola_d = 1'b0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            last_cola_q <= 1'b0;
        else
            last_cola_q <= last_cola_d;
    end

    assign prefer_cola = ~last_cola_q;
`else
    assign prefer_cola = 1'b1;
`endif

    assign pick_cola   = (cola_pend_q != '0) && ((change_pend_q == '0) || prefer_cola);
    assign pick_change = (change_pend_q != '0) && !pick_cola;
    assign cola_acc    = pi_cola && (cola_pend_q != PMAX);
    assign change_acc  = pi_change && (change_pend_q != PMAX);

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        launch       = 1'b0;
        start_cola   = 1'b0;
        start_change = 1'b0;

        case (state_q)
            ST_IDLE: launch = 1'b1;
            ST_COLA_ON, ST_CHANGE_ON: begin
                if (tmr_zero) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    launch  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // GAP expiry jumps straight into the next dispense when work is queued.
        if (launch && (pick_cola || pick_change)) begin
            state_d      = pick_cola ? ST_COLA_ON : ST_CHANGE_ON;
            tmr_load     = 1'b1;
            tmr_val      = TW'(HOLD_CYC - 1);
            start_cola   = pick_cola;
            start_change = pick_change;
        end

        cola_pend_d = cola_pend_q;
        if (cola_acc && !start_cola)
            cola_pend_d = cola_pend_q + CNT_W'(1);
        else if (!cola_acc && start_cola)
            cola_pend_d = cola_pend_q - CNT_W'(1);

        change_pend_d = change_pend_q;
        if (change_acc && !start_change)
            change_pend_d = change_pend_q + CNT_W'(1);
        else if (!change_acc && start_change)
            change_pend_d = change_pend_q - CNT_W'(1);

        ovf_d = ovf_q | (pi_cola && !cola_acc) | (pi_change && !change_acc);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            cola_pend_q   <= '0;
            change_pend_q <= '0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            cola_drv_q    <= 1'b0;
            change_drv_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cola_pend_q   <= cola_pend_d;
            change_pend_q <= change_pend_d;
            ovf_q         <= ovf_d;
            busy_q        <= (state_d != ST_IDLE) || (cola_pend_d != '0) || (change_pend_d != '0);
            cola_drv_q    <= (state_d == ST_COLA_ON);
            change_drv_q  <= (state_d == ST_CHANGE_ON);
        end
    end

    assign po_cola_drv    = cola_drv_q;
    assign po_change_drv  = change_drv_q;
    assign po_busy        = busy_q;
    assign po_overflow    = ovf_q;
    assign po_cola_pend   = cola_pend_q;
    assign po_change_pend = change_pend_q;

endmodule

// File: tb/tb_vend_dispense_seq.sv
// Bench for vend_dispense_seq: expected dispense order is queued with the stimulus and
// popped by a drive monitor that also checks hold length, gap length and non-overlap.
module tb_vend_dispense_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pi_cola = 1'b0;
    logic       pi_change = 1'b0;
    logic       po_cola_drv, po_change_drv, po_busy, po_overflow;
    logic [2:0] po_cola_pend, po_change_pend;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    vend_dispense_seq #(
        .CLK_HZ   (1000),
        .PULSE_MS (4),
        .GAP_MS   (2),
        .CNT_W    (3)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .pi_cola        (pi_cola),
        .pi_change      (pi_change),
        .po_cola_drv    (po_cola_drv),
        .po_change_drv  (po_change_drv),
        .po_busy        (po_busy),
        .po_overflow    (po_overflow),
        .po_cola_pend   (po_cola_pend),
        .po_change_pend (po_change_pend)
    );

    always #5 sys_clk = ~sys_clk;

    // Drive monitor
    logic prev_cola = 1'b0, prev_chg = 1'b0;
    int   cola_hi = 0, chg_hi = 0, low_cnt = 0;
    bit   seen_fall = 1'b0;

    always @(negedge sys_clk) begin
        logic [7:0] e;
        if (!mon_en || sys_rst) begin
            prev_cola = 1'b0; prev_chg = 1'b0;
            cola_hi = 0; chg_hi = 0; low_cnt = 0; seen_fall = 1'b0;
        end else begin
            if (po_cola_drv || po_change_drv) begin
                checks++;
                if (po_cola_drv && po_change_drv) begin
                    errors++;
                    $display("FAIL drive_overlap: cola=%0b change=%0b, required not both high", po_cola_drv, po_change_drv);
                end
            end
            if (po_cola_drv && !prev_cola) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dispense_order: got cola, required no dispense");
                end else begin
                    e = exp_q.pop_front();
                    if (e !== "C") begin
                        errors++;
                        $display("FAIL dispense_order: got C, required %c", e);
                    end
                end
                if (seen_fall) begin
                    checks++;
                    if (low_cnt < 2) begin
                        errors++;
                        $display("FAIL gap_len: got %0d low cycles, required >= 2", low_cnt);
                    end
                end
                low_cnt = 0;
                cola_hi = 1;
            end else if (po_cola_drv) begin
                cola_hi++;
            end
            if (po_change_drv && !prev_chg) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dispense_order: got change, required no dispense");
                end else begin
                    e = exp_q.pop_front();
                    if (e !== "H") begin
                        errors++;
                        $display("FAIL dispense_order: got H, required %c", e);
                    end
                end
                if (seen_fall) begin
                    checks++;
                    if (low_cnt < 2) begin
                        errors++;
                        $display("FAIL gap_len: got %0d low cycles, required >= 2", low_cnt);
                    end
                end
                low_cnt = 0;
                chg_hi = 1;
            end else if (po_change_drv) begin
                chg_hi++;
            end
            if (!po_cola_drv && prev_cola) begin
                checks++;
                seen_fall = 1'b1;
                if (cola_hi != 4) begin
                    errors++;
                    $display("FAIL cola_hold: got %0d cycles, required 4", cola_hi);
                end
            end
            if (!po_change_drv && prev_chg) begin
                checks++;
                seen_fall = 1'b1;
                if (chg_hi != 4) begin
                    errors++;
                    $display("FAIL change_hold: got %0d cycles, required 4", chg_hi);
                end
            end
            if (!po_cola_drv && !po_change_drv)
                low_cnt++;
            prev_cola = po_cola_drv;
            prev_chg  = po_change_drv;
        end
    end

    task automatic test_reset();
        logic [9:0] outs;
        #1;
        outs = {po_cola_drv, po_change_drv, po_busy, po_overflow, po_cola_pend, po_change_pend};
        checks++;
        if (outs !== 10'd0) begin
            errors++;
            $display("FAIL reset_initial: got %b, required 0", outs);
        end
        @(negedge sys_clk) sys_rst = 1'b0;
        repeat (30) begin
            @(negedge sys_clk);
            pi_cola   = ($urandom_range(0, 2) == 0);
            pi_change = ($urandom_range(0, 2) == 0);
        end
        #2 sys_rst = 1'b1;
        #1;
        outs = {po_cola_drv, po_change_drv, po_busy, po_overflow, po_cola_pend, po_change_pend};
        checks++;
        if (outs !== 10'd0) begin
            errors++;
            $display("FAIL reset_async: got %b, required 0", outs);
        end
        repeat (3) begin
            @(negedge sys_clk);
            pi_cola   = $urandom_range(0, 1);
            pi_change = $urandom_range(0, 1);
            outs = {po_cola_drv, po_change_drv, po_busy, po_overflow, po_cola_pend, po_change_pend};
            checks++;
            if (outs !== 10'd0) begin
                errors++;
                $display("FAIL reset_held: got %b, required 0", outs);
            end
        end
        pi_cola = 1'b0; pi_change = 1'b0;
        @(negedge sys_clk) sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (po_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b, required 0", po_busy);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        @(negedge sys_clk) pi_cola = 1'b1;
        exp_q.push_back("C");
        @(negedge sys_clk) pi_cola = 1'b0;
        checks++;
        if (po_cola_pend !== 3'd1 || po_cola_drv !== 1'b0) begin
            errors++;
            $display("FAIL single_e0: pend=%0d drv=%b, required pend=1 drv=0", po_cola_pend, po_cola_drv);
        end
        @(negedge sys_clk);
        checks++;
        if (po_cola_pend !== 3'd0 || po_cola_drv !== 1'b1) begin
            errors++;
            $display("FAIL single_e1: pend=%0d drv=%b, required pend=0 drv=1", po_cola_pend, po_cola_drv);
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (po_cola_drv !== 1'b1) begin
            errors++;
            $display("FAIL single_e4: drv=%b, required 1", po_cola_drv);
        end
        @(negedge sys_clk);
        checks++;
        if (po_cola_drv !== 1'b0 || po_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: drv=%b busy=%b, required drv=0 busy=1", po_cola_drv, po_busy);
        end
        @(negedge sys_clk);
        checks++;
        if (po_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap2_busy: got %b, required 1", po_busy);
        end
        @(negedge sys_clk);
        checks++;
        if (po_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %b, required 0", po_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_missing: %0d dispenses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_both();
        int n;
        @(negedge sys_clk) sys_rst = 1'b1;
        @(negedge sys_clk) sys_rst = 1'b0;
        @(negedge sys_clk) begin pi_cola = 1'b1; pi_change = 1'b1; end
        exp_q.push_back("C");
        exp_q.push_back("H");
        @(negedge sys_clk) begin pi_cola = 1'b0; pi_change = 1'b0; end
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sys_clk);
            if (!po_busy) begin n = i; break; end
        end
        // cola 4 + gap 2 + change 4 + gap 2, plus the launch edge from IDLE
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL both_duration: got %0d cycles, required 13", n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL both_missing: %0d dispenses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_order();
        int n;
        @(negedge sys_clk) sys_rst = 1'b1;
        @(negedge sys_clk) sys_rst = 1'b0;
`ifdef VEND_DISPENSE_RR_EN
        exp_q.push_back("C"); exp_q.push_back("H"); exp_q.push_back("C"); exp_q.push_back("H");
`else
        exp_q.push_back("C"); exp_q.push_back("C"); exp_q.push_back("H"); exp_q.push_back("H");
`endif
        @(negedge sys_clk) begin pi_cola = 1'b1; pi_change = 1'b1; end
        @(negedge sys_clk);
        @(negedge sys_clk) begin pi_cola = 1'b0; pi_change = 1'b0; end
        checks++;
        if (po_cola_pend !== 3'd1 || po_change_pend !== 3'd2) begin
            errors++;
            $display("FAIL order_pend: cola=%0d change=%0d, required cola=1 change=2", po_cola_pend, po_change_pend);
        end
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sys_clk);
            if (!po_busy) begin n = i; break; end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL order_timeout: busy still %b after 200 cycles, required 0", po_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL order_missing: %0d dispenses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_consume_edge();
        int n;
        // A at E0, B at E2 (queued during hold), C at E7 when B is taken from GAP
        repeat (3) exp_q.push_back("C");
        @(negedge sys_clk) pi_cola = 1'b1;
        @(negedge sys_clk) pi_cola = 1'b0;
        @(negedge sys_clk) pi_cola = 1'b1;
        @(negedge sys_clk) pi_cola = 1'b0;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (po_cola_pend !== 3'd1 || po_cola_drv !== 1'b0) begin
            errors++;
            $display("FAIL edge_before: pend=%0d drv=%b, required pend=1 drv=0", po_cola_pend, po_cola_drv);
        end
        pi_cola = 1'b1;
        @(negedge sys_clk) pi_cola = 1'b0;
        checks++;
        if (po_cola_pend !== 3'd1 || po_cola_drv !== 1'b1) begin
            errors++;
            $display("FAIL edge_consume: pend=%0d drv=%b, required pend=1 drv=1", po_cola_pend, po_cola_drv);
        end
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sys_clk);
            if (!po_busy) begin n = i; break; end
        end
        checks++;
        if (n == 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL edge_total: wait=%0d outstanding=%0d, required wait>0 outstanding=0", n, exp_q.size());
        end
    endtask

    task automatic test_saturate();
        int n;
        // Pulses at E0..E9: starts at E1 and E7, pend hits 7 at E8, the E9 pulse is dropped -> 9 out
        repeat (9) exp_q.push_back("C");
        @(negedge sys_clk) pi_cola = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (i == 10) pi_cola = 1'b0;
            if (i == 7 || i == 8) begin
                checks++;
                if (po_cola_pend !== 3'd6 || po_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_pend6: step=%0d pend=%0d ovf=%b, required pend=6 ovf=0", i, po_cola_pend, po_overflow);
                end
            end
            if (i == 9) begin
                checks++;
                if (po_cola_pend !== 3'd7 || po_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_pend7: pend=%0d ovf=%b, required pend=7 ovf=0", po_cola_pend, po_overflow);
                end
            end
            if (i == 10) begin
                checks++;
                if (po_cola_pend !== 3'd7 || po_overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_overflow: pend=%0d ovf=%b, required pend=7 ovf=1", po_cola_pend, po_overflow);
                end
            end
        end
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sys_clk);
            if (!po_busy) begin n = i; break; end
        end
        checks++;
        if (n == 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sat_total: wait=%0d outstanding=%0d, required wait>0 outstanding=0", n, exp_q.size());
        end
        checks++;
        if (po_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: ovf=%b, required 1", po_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_order();
        test_consume_edge();
        test_saturate();
        repeat (2) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
